// File: rtl/prbs4_checker_pkg.sv
// Shared constants and types for the PRBS4 (x^4 + x^3 + 1) sequence checker.
//   SAMPLE_W : width of one LFSR sample
//   TAP_HI/LO: feedback tap positions XORed to form the new LSB
//   CTR_W    : width of the match/mismatch run counters (thresholds 1..15)
//   state_e  : checker FSM state encoding
//   lfsr_step: one step of the reference LFSR
package prbs4_checker_pkg;

  localparam int unsigned SAMPLE_W = 4;
  localparam int unsigned TAP_HI   = 3;
  localparam int unsigned TAP_LO   = 2;
  localparam int unsigned CTR_W    = 4;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HUNT   = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  // Shift left, feeding the tap XOR into bit 0.
  function automatic sample_t lfsr_step(input sample_t cur);
    return {cur[SAMPLE_W-2:0], cur[TAP_HI] ^ cur[TAP_LO]};
  endfunction

endpackage

// File: rtl/prbs4_next.sv
// Combinational next-value predictor for the PRBS4 sequence.
// Ports:
//   cur    : last received sample
//   pred_c : sample the upstream LFSR should produce next
module prbs4_next
  import prbs4_checker_pkg::*;
(
  input  logic [SAMPLE_W-1:0] cur,
  output logic [SAMPLE_W-1:0] pred_c
);

  always_comb begin
    pred_c = lfsr_step(cur);
  end

endmodule

// File: rtl/prbs4_checker.sv
// PRBS4 sequence checker: acquires lock on an upstream 4-bit LFSR stream,
// then flags and counts mismatched samples until lock is lost.
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous reset, active low
//   in_valid  : in_data holds a new sample this cycle
//   in_data   : sample from the upstream LFSR
//   clr_cnt   : synchronous clear of err_cnt and zero_seen (wins over updates)
//   locked    : checker is synchronised (state LOCKED)
//   err_pulse : one-cycle pulse per mismatched sample while locked
//   err_cnt   : saturating count of mismatched samples while locked
//   zero_seen : sticky flag, an all-zero (lockup) sample was received
module prbs4_checker
  import prbs4_checker_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_data,
  input  logic                clr_cnt,
  output logic                locked,
  output logic                err_pulse,
  output logic [CNT_W-1:0]    err_cnt,
  output logic                zero_seen
);

  localparam logic [CTR_W-1:0] LOCK_TGT = CTR_W'(LOCK_CNT);
  localparam logic [CTR_W-1:0] LOSS_TGT = CTR_W'(LOSS_CNT);

  state_e             state;
  sample_t            prev;
  logic [CTR_W-1:0]   match_cnt;
  logic [CTR_W-1:0]   mm_cnt;

  sample_t            exp_c;
  logic               zero_c;
  logic               miss_c;
  logic [CTR_W-1:0]   match_inc_c;
  logic [CTR_W-1:0]   mm_inc_c;
  logic               cnt_sat_c;

  prbs4_next u_next (
    .cur    (prev),
    .pred_c (exp_c)
  );

  // Sample classification; an all-zero sample is never a valid match.
  always_comb begin
    zero_c      = (in_data == '0);
    miss_c      = zero_c || (in_data != exp_c);
    match_inc_c = match_cnt + CTR_W'(1);
    mm_inc_c    = mm_cnt + CTR_W'(1);
    cnt_sat_c   = &err_cnt;
  end

  // Acquisition/tracking FSM with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      prev      <= '0;
      match_cnt <= '0;
      mm_cnt    <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
      zero_seen <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (in_valid) begin
        prev <= in_data;
        case (state)
          ST_IDLE: begin
            if (zero_c) begin
              zero_seen <= 1'b1;
            end else begin
              state     <= ST_HUNT;
              match_cnt <= '0;
            end
          end
          ST_HUNT: begin
            if (zero_c) begin
              state     <= ST_IDLE;
              zero_seen <= 1'b1;
              match_cnt <= '0;
            end else if (!miss_c) begin
              if (match_inc_c == LOCK_TGT) begin
                state     <= ST_LOCKED;
                locked    <= 1'b1;
                mm_cnt    <= '0;
                match_cnt <= '0;
              end else begin
                match_cnt <= match_inc_c;
              end
            end else begin
              match_cnt <= '0;
            end
          end
          ST_LOCKED: begin
            if (!miss_c) begin
              mm_cnt <= '0;
            end else begin
              err_pulse <= 1'b1;
              if (!cnt_sat_c) begin
                err_cnt <= err_cnt + CNT_W'(1);
              end
              if (zero_c) begin
                zero_seen <= 1'b1;
              end
              // The losing mismatch is still counted above.
              if (mm_inc_c == LOSS_TGT) begin
                state     <= ST_HUNT;
                locked    <= 1'b0;
                match_cnt <= '0;
                mm_cnt    <= '0;
              end else begin
                mm_cnt <= mm_inc_c;
              end
            end
          end
          default: begin
            state  <= ST_IDLE;
            locked <= 1'b0;
          end
        endcase
      end
      // Clear has priority over any same-cycle increment or flag set.
      if (clr_cnt) begin
        err_cnt   <= '0;
        zero_seen <= 1'b0;
      end
    end
  end

endmodule
